seq_multiplier: RTL and testbench

Parametrised multi-cycle shift-add multiplier with valid/ready handshakes on input and output, plus selectable unsigned or two's-complement signed mode. It is the sequential successor to the combinational N-bit multiplier. It trades one product per N+2 cycles for a single N-bit adder instead of a full array, and it slots into datapaths that already use valid/ready streams.

---
 rtl/seq_multiplier.sv | 120 ++++++++++++
 tb/tb_seq_multiplier.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle shift-add multiplier with valid/ready handshakes
//
// Computes a*b in N iterations of a single N-bit adder, unsigned or two's
// complement (selected per operation by signed_mode).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand pair and mode present
//   in_ready     block can accept operands (high only in IDLE)
//   a            multiplicand, N bits
//   b            multiplier, N bits
//   signed_mode  1 = two's complement operands/result, 0 = unsigned
//   out_valid    prod holds a finished result
//   out_ready    consumer accepts prod
//   prod         registered 2N-bit result
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] prod
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic           neg;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     sum;
  logic [2*N-1:0] acc_nxt;
  logic           accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Negating -2^(N-1) in N bits yields the same bit pattern, which read as
  // unsigned is exactly the required magnitude 2^(N-1).
  assign a_mag = (signed_mode && a[N-1]) ? -a : a;
  assign b_mag = (signed_mode && b[N-1]) ? -b : b;

  // The carry out of the upper-half add becomes the new MSB after the shift.
  assign sum     = {1'b0, acc[2*N-1:N]} + (mplier[0] ? {1'b0, mcand} : '0);
  assign acc_nxt = {sum, acc[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == LAST) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      prod      <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            neg    <= signed_mode & (a[N-1] ^ b[N-1]);
            acc    <= '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          acc    <= acc_nxt;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            prod      <= neg ? -acc_nxt : acc_nxt;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier (N=8 and N=4)
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        in_valid4, in_ready4, sm4, out_valid4, out_ready4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  seq_multiplier #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .prod(prod8)
  );

  seq_multiplier #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .signed_mode(sm4), .out_valid(out_valid4),
    .out_ready(out_ready4), .prod(prod4)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit sweep_done = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int ix = sm ? int'($signed(x)) : int'(x);
    int iy = sm ? int'($signed(y)) : int'(y);
    return 16'(ix * iy);
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic sm);
    int ix = sm ? int'($signed(x)) : int'(x);
    int iy = sm ? int'($signed(y)) : int'(y);
    return 8'(ix * iy);
  endfunction

  // Transaction-level model: an accepted operation is outstanding until its
  // output handshake; the result must appear exactly N edges after accept.
  bit          pend8, pend4;
  int          t8, t4;
  logic [15:0] exp8;
  logic [7:0]  exp4;
  int          acc8 = 0, done8 = 0, acc4 = 0, done4 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (pend8) acc8--;
      if (pend4) acc4--;
      pend8 = 1'b0;
      pend4 = 1'b0;
      chk("rst_in_ready8", 32'(in_ready8), 32'd1);
      chk("rst_out_valid8", 32'(out_valid8), 32'd0);
      chk("rst_prod8", 32'(prod8), 32'd0);
      chk("rst_in_ready4", 32'(in_ready4), 32'd1);
      chk("rst_out_valid4", 32'(out_valid4), 32'd0);
      chk("rst_prod4", 32'(prod4), 32'd0);
    end else begin
      chk("in_ready8", 32'(in_ready8), 32'(!pend8));
      chk("out_valid8", 32'(out_valid8), 32'(pend8 && cyc >= t8 + 8));
      if (pend8 && cyc >= t8 + 8) begin
        chk("prod8", 32'(prod8), 32'(exp8));
        if (out_ready8) begin pend8 = 1'b0; done8++; end
      end else if (!pend8 && in_valid8) begin
        pend8 = 1'b1; t8 = cyc + 1; exp8 = ref8(a8, b8, sm8); acc8++;
      end

      chk("in_ready4", 32'(in_ready4), 32'(!pend4));
      chk("out_valid4", 32'(out_valid4), 32'(pend4 && cyc >= t4 + 4));
      if (pend4 && cyc >= t4 + 4) begin
        chk("prod4", 32'(prod4), 32'(exp4));
        if (out_ready4) begin pend4 = 1'b0; done4++; end
      end else if (!pend4 && in_valid4) begin
        pend4 = 1'b1; t4 = cyc + 1; exp4 = ref4(a4, b4, sm4); acc4++;
      end
    end
  end

  // One full N=8 operation with out_ready high; checks latency, in_ready
  // low-time and the hand-computed product.
  task automatic do8(input logic [7:0] x, input logic [7:0] y, input logic sm,
                     input logic [15:0] expv, input string nm);
    int lat;
    int low;
    @(posedge clk); #1;
    a8 = x; b8 = y; sm8 = sm; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    low = in_ready8 ? 0 : 1;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!in_ready8) low++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'd8);
    chk({nm, "_prod"}, 32'(prod8), 32'(expv));
    @(posedge clk); #1;
    if (!in_ready8) low++;
    chk({nm, "_in_ready_low"}, 32'(low), 32'd9);
    chk({nm, "_out_valid_clr"}, 32'(out_valid8), 32'd0);
  endtask

  task automatic sweep8(input int n);
    int to;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      to = 0;
      while (!in_ready8 && to < 200) begin @(posedge clk); #1; to++; end
      chk("sweep8_wait", 32'(in_ready8), 32'd1);
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom_range(0, 1));
      in_valid8 = 1'b1;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
    end
  endtask

  task automatic sweep4(input int n);
    int to;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      to = 0;
      while (!in_ready4 && to < 200) begin @(posedge clk); #1; to++; end
      chk("sweep4_wait", 32'(in_ready4), 32'd1);
      a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom_range(0, 1));
      in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0;
    end
  endtask

  initial begin
    int to;
    rst_n = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b0;
    in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    do8(8'd5, 8'd3, 1'b0, 16'd15, "u_5x3");
    do8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
    do8(8'h80, 8'h80, 1'b1, 16'h4000, "s_min_sq");
    do8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_max_min");
    do8(8'h00, 8'h85, 1'b1, 16'h0000, "s_zero");
    do8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_sq");
    do8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_m1_sq");

    // Back-pressure with a stray operand pulse while DONE.
    @(posedge clk); #1;
    a8 = 8'd7; b8 = 8'd6; sm8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    to = 0;
    while (!out_valid8 && to < 40) begin @(posedge clk); #1; to++; end
    chk("bp_out_valid_rise", 32'(out_valid8), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a8 = 8'd9; b8 = 8'd9; in_valid8 = 1'b1; end
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      chk("bp_prod_held", 32'(prod8), 32'd42);
      chk("bp_in_ready", 32'(in_ready8), 32'd0);
      chk("bp_out_valid", 32'(out_valid8), 32'd1);
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ov", 32'(out_valid8), 32'd0);
    chk("bp_release_ir", 32'(in_ready8), 32'd1);
    do8(8'd9, 8'd9, 1'b0, 16'd81, "after_bp");

    // Asynchronous reset during the 4th BUSY cycle.
    @(posedge clk); #1;
    a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_ov", 32'(out_valid8), 32'd0);
    chk("async_rst_prod", 32'(prod8), 32'd0);
    chk("async_rst_ir", 32'(in_ready8), 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    do8(8'd12, 8'd13, 1'b0, 16'd156, "post_rst");

    // Randomised sweep on both widths with random output stalls.
    fork
      begin
        fork
          sweep8(40);
          sweep4(40);
        join
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(posedge clk); #1;
          out_ready8 = 1'($urandom_range(0, 1));
          out_ready4 = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready8 = 1'b1;
    out_ready4 = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain8", 32'(done8), 32'(acc8));
    chk("drain4", 32'(done4), 32'd40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
